demux4_registered: RTL and testbench
====================================

# demux4_registered

Registered 1-to-4 demultiplexer with per-lane valid/ready handshakes. It steers a single input word to one of four output lanes and holds it there until the downstream consumer of that lane accepts it. It is the distribution counterpart to the registered 4-input select path in the CPU datapath, fanning one producer (for example the ALU result or a load return) out to four independent consumers. Each lane has its own one-entry holding register, so a stalled lane never blocks traffic to the other lanes.

## Interface
- WIDTH, 8, data width of input and of each lane
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (asserted when 0)
- in_valid  input  1  input word present
- in_ready  output  1  input word accepted this cycle when in_valid is also 1
- sel  input  2  destination lane index, 0..3
- din  input  WIDTH  input word
- bcast  input  1  broadcast request; exists only with DEMUX4_BCAST_EN
- out_valid  output  4  lane i holds a word
- out_ready  input  4  consumer i takes its word this cycle
- out0, out1, out2, out3  output  WIDTH each  lane holding registers

## Operation
- Lane i is free when out_valid[i]=0 or out_ready[i]=1.
- in_ready = free(sel), combinational. It is independent of in_valid, so there is no loop.
- Accept happens when in_valid && in_ready. On the next edge: out{sel} <= din and out_valid[sel] <= 1.
- Drain on lane i happens when out_valid[i] && out_ready[i].
  - If the same edge also loads lane i, out_valid[i] stays 1 and the new word replaces the old one.
  - Otherwise out_valid[i] <= 0.
- A lane's data register changes only on a load. After a drain the stale value remains visible while out_valid is 0.
- sel, din and bcast are sampled only on an accept. Changing them while in_ready=0 is legal, and the handshake is evaluated against the new sel.
- out_ready on a lane with out_valid=0 has no effect.
- Lanes are independent. Drains on any subset of lanes and one load can all occur on the same edge.

## Timing
- Reset (rst=0, asynchronous):
  - out_valid = 4'b0000 and out0..out3 = 0 immediately.
  - in_ready follows combinationally: 1, because all lanes are free.
- Reset mid-operation discards all held words. No partial state survives.
- Deassertion is synchronous to the design. The first accept is possible on the first rising edge with rst=1.
- Latency is 1 cycle: a word accepted at edge T is visible on out{sel} with out_valid high after edge T.
- Throughput is one word per cycle to any lane, including back-to-back words to the same lane if its consumer holds out_ready=1.
- A full lane with out_ready=0 holds in_ready=0 for that sel indefinitely. Words are never dropped or overwritten without a drain.

## Configuration
- DEMUX4_BCAST_EN defined:
  - The bcast port exists.
  - When bcast=1, in_ready = free(0) & free(1) & free(2) & free(3), and sel is ignored.
  - An accept loads din into all four lanes and sets out_valid = 4'b1111 on the same edge.
  - When bcast=0, behaviour is as described in Operation.
- DEMUX4_BCAST_EN undefined:
  - The bcast port is absent and the broadcast logic is not generated.
  - in_ready always equals free(sel).

## Structure
- Shared package cpu_pkg holds:
  - the lane-count constant DEMUX_LANES = 4;
  - the lane-index typedef lane_sel_t (2 bits);
  - the lane enumeration LANE0..LANE3.
- Sub-module demux_lane (parameter WIDTH) is instantiated four times. It contains:
  - the holding register and valid flag;
  - the free output;
  - inputs for load, din and out_ready;
  - the asynchronous active-low reset on both data and valid.
- The top level contains only sel decode, broadcast qualification and the in_ready mux.

## Test plan
- Reset and single load:
  - Stimulus: hold rst=0 with out_ready=0; release; in_valid=1, sel=2, din=8'hA5 for one cycle.
  - Required: during reset out_valid=0000, out0..3=0, in_ready=1. After the edge, out_valid=0100 and out2=A5.
- Backpressure:
  - Stimulus: lane 1 holds 8'h11 with out_ready[1]=0; present sel=1, din=8'h22.
  - Required: in_ready=0 and out1 stays 11 for 5 cycles. Raising out_ready[1] gives in_ready=1; after the next edge out1=22 and out_valid[1]=1.
- Independent lanes:
  - Stimulus: lane 0 full and stalled; present sel=3, din=8'h3C.
  - Required: in_ready=1; after the edge out3=3C, out_valid=1001, and out0 is unchanged.
- Simultaneous drain and load:
  - Stimulus: 4 consecutive words 01, 02, 03, 04 to sel=0 with out_ready[0]=1 throughout.
  - Required: in_ready stays 1, out0 shows 01..04 on successive cycles, and out_valid[0] stays high.
- Reset mid-operation:
  - Stimulus: with out_valid=1111, pulse rst=0 between edges.
  - Required: out_valid=0000 and all outputs are 0 immediately, without waiting for a clock edge.
- Broadcast (DEMUX4_BCAST_EN):
  - Stimulus: lane 2 full and stalled; bcast=1, din=8'h7E.
  - Required: in_ready=0. After out_ready[2] is pulsed, the accept yields out_valid=1111 and out0..3=7E.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions.
// Lane count and lane-index types for the result demultiplexer.
package cpu_pkg;

    localparam int DEMUX_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    typedef enum lane_sel_t {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

endpackage

// File: rtl/demux_lane.sv
// One-entry holding register with valid flag for a single demux lane.
// The data register only changes on load, so stale data stays visible.
module demux_lane #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    assign free = ~valid | out_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= din;
        end else if (out_ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux4_registered.sv
// Registered 1-to-4 demux with per-lane valid/ready handshakes.
// Optional broadcast to all lanes under DEMUX4_BCAST_EN.
module demux4_registered
    import cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             sel,
    input  logic [WIDTH-1:0]       din,
`ifdef DEMUX4_BCAST_EN
    input  logic                   bcast,
`endif
    output logic [DEMUX_LANES-1:0] out_valid,
    input  logic [DEMUX_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]       out0,
    output logic [WIDTH-1:0]       out1,
    output logic [WIDTH-1:0]       out2,
    output logic [WIDTH-1:0]       out3
);

    logic [DEMUX_LANES-1:0] free;
    logic [DEMUX_LANES-1:0] sel_oh;
    logic [DEMUX_LANES-1:0] load;
    logic [WIDTH-1:0]       lane_data [DEMUX_LANES];
    logic                   accept;

    always_comb begin
        sel_oh = '0;
        unique case (lane_sel_t'(sel))
            LANE0: sel_oh = 4'b0001;
            LANE1: sel_oh = 4'b0010;
            LANE2: sel_oh = 4'b0100;
            LANE3: sel_oh = 4'b1000;
            default: sel_oh = '0;
        endcase
    end

`ifdef DEMUX4_BCAST_EN
    // Broadcast needs every lane free; sel is ignored.
    assign in_ready = bcast ? &free : |(free & sel_oh);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? (bcast ? '1 : sel_oh) : '0;
`else
    assign in_ready = |(free & sel_oh);
    assign accept   = in_valid & in_ready;
    assign load     = accept ? sel_oh : '0;
`endif

    for (genvar i = 0; i < DEMUX_LANES; i++) begin : g_lane
        demux_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .load     (load[i]),
            .din      (din),
            .out_ready(out_ready[i]),
            .valid    (out_valid[i]),
            .data     (lane_data[i]),
            .free     (free[i])
        );
    end

    assign out0 = lane_data[0];
    assign out1 = lane_data[1];
    assign out2 = lane_data[2];
    assign out3 = lane_data[3];

endmodule

// File: tb/tb_demux4_registered.sv
// Self-checking bench for demux4_registered: directed cases plus random
// traffic compared every cycle against a behavioural lane model.
module tb_demux4_registered;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [7:0] din;
    logic       bcast;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out0, out1, out2, out3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: what each lane holds and whether it is occupied
    bit       m_full [4];
    bit [7:0] m_word [4];

    always #5 clk = ~clk;

    demux4_registered #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .din      (din),
`ifdef DEMUX4_BCAST_EN
        .bcast    (bcast),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out0     (out0),
        .out1     (out1),
        .out2     (out2),
        .out3     (out3)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit lane_can_take(int i);
        return !m_full[i] || out_ready[i];
    endfunction

    function automatic bit model_ready();
        bit all_free;
        all_free = 1'b1;
        for (int i = 0; i < 4; i++) all_free &= lane_can_take(i);
`ifdef DEMUX4_BCAST_EN
        if (bcast) return all_free;
`endif
        return lane_can_take(int'(sel));
    endfunction

    function automatic logic [7:0] dut_lane(int i);
        case (i)
            0: return out0;
            1: return out1;
            2: return out2;
            default: return out3;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                m_full[i] = 1'b0;
                m_word[i] = 8'h00;
            end
        end else begin
            bit take;
            bit to_all;
            take = in_valid && model_ready();
            to_all = 1'b0;
`ifdef DEMUX4_BCAST_EN
            to_all = bcast;
`endif
            for (int i = 0; i < 4; i++)
                if (m_full[i] && out_ready[i]) m_full[i] = 1'b0;
            if (take) begin
                for (int i = 0; i < 4; i++) begin
                    if (to_all || i == int'(sel)) begin
                        m_full[i] = 1'b1;
                        m_word[i] = din;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] mv;
        for (int i = 0; i < 4; i++) mv[i] = m_full[i];
        chk("model out_valid", {28'd0, out_valid}, {28'd0, mv});
        chk("model in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        for (int i = 0; i < 4; i++)
            chk($sformatf("model out%0d", i), {24'd0, dut_lane(i)},
                {24'd0, m_word[i]});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        bcast     = 1'b0;
    endtask

    task automatic put(input logic [1:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        sel      = s;
        din      = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle();
        sel = 2'd0;
        din = 8'h00;
        step();
        step();
        chk("rst out_valid", {28'd0, out_valid}, 32'h0);
        chk("rst outs", {out0, out1, out2, out3}, 32'h0);
        chk("rst in_ready", {31'd0, in_ready}, 32'h1);
        rst = 1'b1;

        put(2'd2, 8'hA5);
        chk("load out_valid", {28'd0, out_valid}, 32'b0100);
        chk("load out2", {24'd0, out2}, 32'hA5);

        put(2'd1, 8'h11);
        in_valid = 1'b1;
        sel      = 2'd1;
        din      = 8'h22;
        for (int k = 0; k < 5; k++) begin
            chk("bp in_ready", {31'd0, in_ready}, 32'h0);
            chk("bp out1", {24'd0, out1}, 32'h11);
            step();
        end
        out_ready[1] = 1'b1;
        #1;
        chk("bp release in_ready", {31'd0, in_ready}, 32'h1);
        step();
        chk("bp out1 new", {24'd0, out1}, 32'h22);
        chk("bp valid1", {31'd0, out_valid[1]}, 32'h1);
        idle();

        out_ready = 4'b0110;
        step();
        out_ready = 4'b0000;
        put(2'd0, 8'h5A);
        sel = 2'd3;
        din = 8'h3C;
        #1;
        chk("indep in_ready", {31'd0, in_ready}, 32'h1);
        put(2'd3, 8'h3C);
        chk("indep out3", {24'd0, out3}, 32'h3C);
        chk("indep out_valid", {28'd0, out_valid}, 32'b1001);
        chk("indep out0", {24'd0, out0}, 32'h5A);

        out_ready[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1;
            sel      = 2'd0;
            din      = 8'(k);
            #1;
            chk("dl in_ready", {31'd0, in_ready}, 32'h1);
            step();
            chk("dl out0", {24'd0, out0}, k);
            chk("dl valid0", {31'd0, out_valid[0]}, 32'h1);
        end
        idle();

        put(2'd0, 8'hC0);
        put(2'd1, 8'hC1);
        put(2'd2, 8'hC2);
        chk("pre-rst out_valid", {28'd0, out_valid}, 32'b1111);
        #2;
        rst = 1'b0;
        #1;
        chk("mid-rst out_valid", {28'd0, out_valid}, 32'h0);
        chk("mid-rst outs", {out0, out1, out2, out3}, 32'h0);
        chk("mid-rst in_ready", {31'd0, in_ready}, 32'h1);
        rst = 1'b1;
        step();

`ifdef DEMUX4_BCAST_EN
        put(2'd2, 8'h99);
        in_valid = 1'b1;
        bcast    = 1'b1;
        sel      = 2'd0;
        din      = 8'h7E;
        #1;
        chk("bc blocked", {31'd0, in_ready}, 32'h0);
        step();
        out_ready[2] = 1'b1;
        #1;
        chk("bc ready", {31'd0, in_ready}, 32'h1);
        step();
        idle();
        chk("bc out_valid", {28'd0, out_valid}, 32'b1111);
        chk("bc outs", {out0, out1, out2, out3}, 32'h7E7E7E7E);
        out_ready = 4'b1111;
        step();
        idle();
`endif

        for (int k = 0; k < 2000; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            din       = 8'($urandom);
            out_ready = 4'($urandom);
`ifdef DEMUX4_BCAST_EN
            bcast = ($urandom_range(0, 3) == 0);
`endif
            step();
        end
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
